// File: rtl/frame_store_mbuf.sv
// frame_store_mbuf: buffers a stream of pixel words in a small synchronous FIFO
// and writes it to SDRAM in bursts through the arbiter write port. Frames go
// round-robin into NUM_BUFS buffers. The index of the last completed buffer is
// published to the readback side. An end-of-frame flush drains any partial burst.
module frame_store_mbuf #(
  parameter int                DATA_W      = 128,
  parameter int                ADDR_W      = 25,
  parameter int                ADDR_INC    = 4,
  parameter int                BURST_LEN   = 8,
  parameter int                FIFO_DEPTH  = 32,
  parameter int                NUM_BUFS    = 2,
  parameter logic [ADDR_W-1:0] BUF_BASE    = 'hE1000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE  = 'h25800,
  parameter int                FRAME_WORDS = 38400,
  localparam int               BIW         = ($clog2(NUM_BUFS) > 1) ? $clog2(NUM_BUFS) : 1,
  localparam int               LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_133M,
  input  logic              rst_133M,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              frame_done,
  input  logic              ram_busy,
  input  logic              clr_err,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  output logic [BIW-1:0]    last_buf,
  output logic              buf_swap,
  output logic [LW-1:0]     fifo_level,
  output logic              fifo_ovf,
  output logic              frame_ovr
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FRAME_WORDS + 1);
  localparam int BCW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH, S_SWAP} state_t;

  state_t            r_state, w_next_state;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_word_cnt;
  logic [BCW-1:0]    r_burst_cnt;
  logic [BIW-1:0]    r_cur_buf, r_last_buf;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pend_done, r_buf_swap, r_fifo_ovf, r_frame_ovr;

  logic [LW-1:0]     w_level;
  logic              w_full, w_empty, w_cnt_ok, w_push, w_consume, w_wr_req;
  logic [BIW-1:0]    w_next_buf;
  logic [ADDR_W-1:0] w_next_base;

  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_level == LW'(FIFO_DEPTH));
  assign w_empty     = (w_level == '0);
  // The word count restarts in SWAP, so a push in that cycle opens the new frame.
  assign w_cnt_ok    = (r_word_cnt < CW'(FRAME_WORDS)) || (r_state == S_SWAP);
  assign w_push      = in_valid && !w_full && w_cnt_ok;
  assign w_consume   = w_wr_req && !ram_busy;
  assign w_next_buf  = (r_cur_buf == BIW'(NUM_BUFS - 1)) ? '0 : r_cur_buf + 1'b1;
  assign w_next_base = BUF_BASE + ADDR_W'(w_next_buf) * BUF_STRIDE;

  // FIFO storage: write on accepted push; head is read combinationally.
  // NOTE: the data array has no reset; emptiness is defined purely by the
  // pointers, so clearing entries would only cost reset fanout.
  always_ff @(posedge clk_133M) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= in_data;
  end

  // FIFO pointers; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_consume) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: full bursts take priority over a pending end-of-frame flush.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_level >= LW'(BURST_LEN)) w_next_state = S_BURST;
        else if (r_pend_done)          w_next_state = S_FLUSH;
      end
      S_BURST: if (w_consume && (r_burst_cnt == BCW'(1))) w_next_state = S_IDLE;
      S_FLUSH: if (w_empty && !w_push)                    w_next_state = S_SWAP;
      S_SWAP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: request words during a burst, or during a flush while data remains.
  always_comb begin
    w_wr_req = 1'b0;
    case (r_state)
      S_BURST: w_wr_req = 1'b1;
      S_FLUSH: w_wr_req = !w_empty;
      default: w_wr_req = 1'b0;
    endcase
  end

  // Burst word counter, loaded on entry to BURST.
  always_ff @(posedge clk_133M) begin
    if (rst_133M)                                       r_burst_cnt <= '0;
    else if (r_state == S_IDLE && w_next_state == S_BURST) r_burst_cnt <= BCW'(BURST_LEN);
    else if (r_state == S_BURST && w_consume)           r_burst_cnt <= r_burst_cnt - 1'b1;
  end

  // End-of-frame latch; repeated frame_done pulses before the swap merge into one.
  always_ff @(posedge clk_133M) begin
    if (rst_133M)               r_pend_done <= 1'b0;
    else if (frame_done)        r_pend_done <= 1'b1;
    else if (r_state == S_SWAP) r_pend_done <= 1'b0;
  end

  // Per-frame accepted-word count.
  always_ff @(posedge clk_133M) begin
    if (rst_133M)               r_word_cnt <= '0;
    else if (r_state == S_SWAP) r_word_cnt <= w_push ? CW'(1) : '0;
    else if (w_push)            r_word_cnt <= r_word_cnt + 1'b1;
  end

  // Buffer rotation; buf_swap is registered so it coincides with the new last_buf.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      r_cur_buf  <= '0;
      r_last_buf <= BIW'(NUM_BUFS - 1);
      r_buf_swap <= 1'b0;
    end else begin
      r_buf_swap <= (r_state == S_SWAP);
      if (r_state == S_SWAP) begin
        r_last_buf <= r_cur_buf;
        r_cur_buf  <= w_next_buf;
      end
    end
  end

  // Write address: steps per consumed word and jumps to the next buffer base on swap.
  always_ff @(posedge clk_133M) begin
    if (rst_133M)               r_addr <= BUF_BASE;
    else if (r_state == S_SWAP) r_addr <= w_next_base;
    else if (w_consume)         r_addr <= r_addr + ADDR_W'(ADDR_INC);
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk_133M) begin
    if (rst_133M) begin
      r_fifo_ovf  <= 1'b0;
      r_frame_ovr <= 1'b0;
    end else begin
      if (in_valid && w_full)         r_fifo_ovf  <= 1'b1;
      else if (clr_err)               r_fifo_ovf  <= 1'b0;
      if (in_valid && !w_cnt_ok)      r_frame_ovr <= 1'b1;
      else if (clr_err)               r_frame_ovr <= 1'b0;
    end
  end

  assign wr_req     = w_wr_req;
  assign wr_address = r_addr;
  assign wr_data    = r_mem[r_rd_ptr[PW-1:0]];
  assign last_buf   = r_last_buf;
  assign buf_swap   = r_buf_swap;
  assign fifo_level = w_level;
  assign fifo_ovf   = r_fifo_ovf;
  assign frame_ovr  = r_frame_ovr;

endmodule

// File: tb/tb_frame_store_mbuf.sv
// Bench for frame_store_mbuf. Three instances are used one at a time:
// 0 has the default configuration, 1 has NUM_BUFS=3, and 2 has FRAME_WORDS=10.
// Expected writes are queued at push time. A monitor pops one entry on every
// consumed word and compares it.
module tb_frame_store_mbuf;

  typedef struct packed {
    logic [1:0]   inst;
    logic [24:0]  addr;
    logic [127:0] data;
  } wr_t;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [2:0]   iv, fd;
  logic         ram_busy, clr_err;

  logic         wr_req   [3];
  logic [24:0]  wr_addr  [3];
  logic [127:0] wr_data  [3];
  logic [1:0]   last_buf [3];
  logic         buf_swap [3];
  logic [5:0]   level    [3];
  logic         ovf      [3];
  logic         ovr      [3];

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BW = (g == 1) ? 2 : 1;
    logic [BW-1:0] lb;
    frame_store_mbuf #(
      .NUM_BUFS   ((g == 1) ? 3 : 2),
      .FRAME_WORDS((g == 2) ? 10 : 38400)
    ) u_dut (
      .clk_133M  (clk),
      .rst_133M  (rst),
      .in_data   (in_data),
      .in_valid  (iv[g]),
      .frame_done(fd[g]),
      .ram_busy  (ram_busy),
      .clr_err   (clr_err),
      .wr_req    (wr_req[g]),
      .wr_address(wr_addr[g]),
      .wr_data   (wr_data[g]),
      .last_buf  (lb),
      .buf_swap  (buf_swap[g]),
      .fifo_level(level[g]),
      .fifo_ovf  (ovf[g]),
      .frame_ovr (ovr[g])
    );
    assign last_buf[g] = 2'(lb);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed word must match the head of the queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!rst && wr_req[g] && !ram_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_write: inst %0d addr %0h data %0h with nothing expected",
                     g, wr_addr[g], wr_data[g]);
          end else begin
            e = exp_q.pop_front();
            check("wr_inst", 160'(g), 160'(e.inst));
            check("wr_addr", 160'(wr_addr[g]), 160'(e.addr));
            check("wr_data", 160'(wr_data[g]), 160'(e.data));
          end
        end
      end
    end
  end

  // Inputs are driven 1 time unit after the rising edge.
  task automatic push(input int g, input logic [127:0] d, input bit exp_wr, input logic [24:0] a);
    wr_t e;
    in_data = d;
    iv[g]   = 1'b1;
    if (exp_wr) begin
      e.inst = 2'(g);
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    iv = '0;
  endtask

  task automatic pulse_fd(input int g, input int len);
    fd[g] = 1'b1;
    repeat (len) @(posedge clk);
    #1;
    fd = '0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic wait_swap(input int g, input logic [1:0] exp_last, input logic [24:0] exp_addr,
                           input string name);
    bit found = 1'b0;
    int n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      if (buf_swap[g]) found = 1'b1;
      n++;
    end
    check({name, "_swap_seen"}, 160'(found), 160'(1));
    if (found) begin
      check({name, "_last_buf"}, 160'(last_buf[g]), 160'(exp_last));
      check({name, "_next_addr"}, 160'(wr_addr[g]), 160'(exp_addr));
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input int g, input string name);
    bit found = 1'b0;
    int n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (wr_req[g]) found = 1'b1;
      n++;
    end
    check({name, "_req_seen"}, 160'(found), 160'(1));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drained"}, 160'(exp_q.size()), 160'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] bases [3];
    bases[0] = 25'hE1000;
    bases[1] = 25'h106800;
    bases[2] = 25'h12C000;

    rst = 1'b1; in_data = '0; iv = '0; fd = '0; ram_busy = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of all three instances.
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_wr_req", 160'(wr_req[g]), 160'(0));
      check("rst_level", 160'(level[g]), 160'(0));
      check("rst_addr", 160'(wr_addr[g]), 160'(25'hE1000));
      check("rst_last_buf", 160'(last_buf[g]), 160'((g == 1) ? 2 : 1));
      check("rst_buf_swap", 160'(buf_swap[g]), 160'(0));
      check("rst_ovf", 160'(ovf[g]), 160'(0));
      check("rst_ovr", 160'(ovr[g]), 160'(0));
    end
    @(posedge clk); #1;

    // T1: one full burst, latency and back-to-back requests.
    for (int i = 0; i < 8; i++) push(0, 128'(i + 1), 1'b1, 25'hE1000 + 25'(4 * i));
    @(negedge clk);
    check("t1_req_after_1", 160'(wr_req[0]), 160'(0));
    @(negedge clk);
    check("t1_req_after_2", 160'(wr_req[0]), 160'(1));
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("t1_req_consec", 160'(wr_req[0]), 160'(1));
    end
    @(negedge clk);
    check("t1_req_end", 160'(wr_req[0]), 160'(0));
    check("t1_all_written", 160'(exp_q.size()), 160'(0));
    @(posedge clk); #1;

    // T2: arbiter busy for 5 cycles mid-burst; outputs must hold.
    for (int i = 0; i < 8; i++) push(0, 128'(8'h11 + i), 1'b1, 25'hE1020 + 25'(4 * i));
    wait_req(0, "t2");
    @(posedge clk); #1;
    ram_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_hold_req", 160'(wr_req[0]), 160'(1));
      check("t2_hold_addr", 160'(wr_addr[0]), 160'(25'hE1024));
      check("t2_hold_data", 160'(wr_data[0]), 160'(128'h12));
    end
    @(posedge clk); #1;
    ram_busy = 1'b0;
    wait_drain("t2");
    check("t2_addr_after", 160'(wr_addr[0]), 160'(25'hE1040));

    // T3: partial frame flush, then an empty frame given as a merged double pulse.
    for (int i = 0; i < 5; i++) push(0, 128'(8'h21 + i), 1'b1, 25'hE1040 + 25'(4 * i));
    pulse_fd(0, 1);
    wait_swap(0, 2'd0, 25'h106800, "t3a");
    check("t3a_drained", 160'(exp_q.size()), 160'(0));
    pulse_fd(0, 2);
    wait_swap(0, 2'd1, 25'hE1000, "t3b");
    begin
      int extra = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (buf_swap[0]) extra++;
      end
      check("t3_merged_single_swap", 160'(extra), 160'(0));
      @(posedge clk); #1;
    end

    // T4: three-buffer rotation on instance 1, including the wrap.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 2; i++)
        push(1, 128'(16'h3000 + 16 * f + i), 1'b1, bases[f % 3] + 25'(4 * i));
      pulse_fd(1, 1);
      wait_swap(1, 2'(f % 3), bases[(f + 1) % 3], "t4");
    end
    check("t4_drained", 160'(exp_q.size()), 160'(0));

    // T5a: FIFO overflow while the arbiter is busy, then clear.
    ram_busy = 1'b1;
    for (int i = 0; i < 33; i++) push(0, 128'(16'h100 + i), (i < 32), 25'hE1000 + 25'(4 * i));
    @(negedge clk);
    check("t5_level_full", 160'(level[0]), 160'(32));
    check("t5_ovf_set", 160'(ovf[0]), 160'(1));
    check("t5_ovr_clear", 160'(ovr[0]), 160'(0));
    @(posedge clk); #1;
    pulse_clr();
    @(negedge clk);
    check("t5_ovf_cleared", 160'(ovf[0]), 160'(0));
    @(posedge clk); #1;
    ram_busy = 1'b0;
    wait_drain("t5a");

    // T5b: frame word limit on instance 2 (FRAME_WORDS=10).
    for (int i = 0; i < 12; i++) push(2, 128'(16'h200 + i), (i < 10), 25'hE1000 + 25'(4 * i));
    @(negedge clk);
    check("t5b_ovr_set", 160'(ovr[2]), 160'(1));
    check("t5b_ovf_clear", 160'(ovf[2]), 160'(0));
    @(posedge clk); #1;
    pulse_fd(2, 1);
    wait_swap(2, 2'd0, 25'h106800, "t5b");
    check("t5b_ten_written", 160'(exp_q.size()), 160'(0));
    pulse_clr();
    @(negedge clk);
    check("t5b_ovr_cleared", 160'(ovr[2]), 160'(0));
    @(posedge clk); #1;

    // T6: reset in the middle of a burst; nothing further may be written.
    ram_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(0, 128'(16'h300 + i), (i == 0), 25'hE1080);
    wait_req(0, "t6");
    @(posedge clk); #1;
    ram_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ram_busy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rst_wr_req", 160'(wr_req[0]), 160'(0));
    check("t6_rst_level", 160'(level[0]), 160'(0));
    check("t6_rst_addr", 160'(wr_addr[0]), 160'(25'hE1000));
    check("t6_rst_last_buf", 160'(last_buf[0]), 160'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    ram_busy = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_no_more_writes", 160'(exp_q.size()), 160'(0));
    check("t6_level_after", 160'(level[0]), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_store_mbuf.md
Name: frame_store_mbuf

Overview:
- Parametrised successor to the single-frame HDR store path.
- Accepts a stream of pixel words, buffers them in an internal synchronous FIFO, and writes them to SDRAM in bursts through the RAM arbiter's write port.
- Rotates round-robin over NUM_BUFS frame buffers and publishes the index of the last completed buffer to the display/readback side.
- Adds overrun and overflow detection plus an end-of-frame flush; the previous block had none of these.

Parameters:
DATA_W, 128, width of pixel word and wr_data
ADDR_W, 25, width of wr_address
ADDR_INC, 4, address step per written word
BURST_LEN, 8, words per normal burst; must be ≤ FIFO_DEPTH
FIFO_DEPTH, 32, internal FIFO entries; power of 2
NUM_BUFS, 2, number of frame buffers; range 2..4
BUF_BASE, 25'hE1000, base address of buffer 0
BUF_STRIDE, 25'h25800, address distance between consecutive buffers
FRAME_WORDS, 38400, maximum words per frame per buffer

Ports:
clk_133M  in  1  system/RAM clock
rst_133M  in  1  synchronous active-high reset
in_data  in  DATA_W  pixel word
in_valid  in  1  in_data valid; pushed this cycle
frame_done  in  1  one-cycle pulse marking the end of the current frame
ram_busy  in  1  arbiter cannot accept a word this cycle
clr_err  in  1  clears the sticky error flags
wr_req  out  1  write word request
wr_address  out  ADDR_W  address of the current word
wr_data  out  DATA_W  data of the current word (FIFO head)
last_buf  out  BIW  index of the last completed buffer; BIW = max(1, clog2(NUM_BUFS))
buf_swap  out  1  one-cycle pulse when last_buf updates
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_ovf  out  1  sticky: push while FIFO full
frame_ovr  out  1  sticky: word beyond FRAME_WORDS dropped

Behaviour:
- Reset (synchronous, rst_133M=1):
  - wr_req=0, buf_swap=0, fifo_ovf=0, frame_ovr=0, fifo_level=0.
  - cur_buf=0, last_buf=NUM_BUFS-1, wr_address=BUF_BASE, word count=0, state=IDLE.
  - FIFO contents are discarded. Reset mid-burst abandons the burst; no further wr_req.
- Transfer rule: a word is consumed exactly in a cycle where wr_req=1 and ram_busy=0. While ram_busy=1, wr_req, wr_address and wr_data hold stable. On consume, the FIFO pops and wr_address += ADDR_INC, wrapping modulo 2^ADDR_W.
- Push path:
  - in_valid=1 with FIFO not full: push; the word is visible at the FIFO head the next cycle.
  - FIFO full, or word count ≥ FRAME_WORDS: drop the word.
    - FIFO full sets fifo_ovf.
    - Count limit reached sets frame_ovr.
  - Word count increments on each accepted push.
  - A push and a pop in the same cycle leave fifo_level unchanged.
- pend_done latch: set by frame_done; cleared on entry to SWAP.
- State machine:
  - IDLE: if fifo_level ≥ BURST_LEN → BURST (burst counter = BURST_LEN). Else if pend_done → FLUSH. wr_req=0.
  - BURST: wr_req=1. Decrement the counter on each consume. After the last word → IDLE. Data availability is guaranteed by the entry condition.
  - FLUSH: wr_req=1 while the FIFO is non-empty. When empty and no push in that cycle → SWAP. Pushes arriving during FLUSH are drained in the same FLUSH.
  - SWAP (one cycle):
    - last_buf ← cur_buf; buf_swap=1.
    - cur_buf ← (cur_buf+1) mod NUM_BUFS.
    - wr_address ← BUF_BASE + next_buf*BUF_STRIDE.
    - Word count ← 0; pend_done ← 0.
    - → IDLE.
- First wr_req after entering BURST or FLUSH occurs the cycle after the state transition; latency from the push that completes a burst to the first wr_req is 2 cycles.
- frame_done with an empty FIFO: FLUSH passes straight through to SWAP, giving an empty-frame swap.
- frame_done during BURST: the burst completes, then FLUSH.
- frame_done while pend_done=1: merged (one swap only).
- Pushes arriving between SWAP and the next frame count toward the new frame.
- clr_err clears both sticky flags. If a set event occurs in the same cycle, set wins.
- Address arithmetic is ADDR_W bits, unsigned; buffer base computation is truncated to ADDR_W.

Test Plan:
- Reset, then push 8 words 0x1..0x8 with ram_busy=0 → 8 consecutive wr_req cycles, addresses E1000, E1004 … E101C, data in order; first wr_req 2 cycles after the 8th push.
- Push 8 words, ram_busy=1 for 5 cycles mid-burst → wr_req/wr_address/wr_data held stable; exactly 8 consumes, no duplicates or losses.
- Push 5 words, then frame_done → FLUSH writes 5 words, then buf_swap pulse, last_buf=0, next write at 106800; second frame_done → last_buf=1, address back to E1000 (NUM_BUFS=2).
- NUM_BUFS=3: three frames → last_buf sequence 0,1,2 with bases E1000, 106800, 12C000; the fourth frame wraps to E1000.
- Hold ram_busy=1 and push 33 words → fifo_ovf=1, fifo_level=32; clr_err → 0. With FRAME_WORDS=10, push 12 words → 10 written, frame_ovr=1.
- Assert rst_133M mid-burst → next cycle wr_req=0, fifo_level=0, wr_address=E1000, last_buf=NUM_BUFS-1.
